// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, then commits the store or returns the load
// data with an error flag for illegal addresses.
// Optional feature: define MEM_RESP_MISALIGN_CHECK_EN to flag addr[1:0] != 0 as an error.
module data_mem_responder #(
    parameter int SIZE        = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IdxW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

    stateT       state;
    logic [3:0]  count;
    logic        latWrite;
    logic [31:0] latAddr;
    logic [31:0] latWdata;
    logic [31:0] mem [SIZE];

    logic            selWrite;
    logic [31:0]     selAddr;
    logic [31:0]     selWdata;
    logic            commitNow;
    logic            outOfRange;
    logic            misaligned;
    logic            accessErr;
    logic [IdxW-1:0] memIdx;

    // With zero wait states the commit happens on the accepting edge, so use the live request
    // fields in IDLE and the latched ones otherwise.
    always_comb begin
        if (state == StIdle) begin
            selWrite = req_write;
            selAddr  = req_addr;
            selWdata = req_wdata;
        end else begin
            selWrite = latWrite;
            selAddr  = latAddr;
            selWdata = latWdata;
        end
    end

    assign commitNow  = ((state == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state == StWait) && (count == 4'd1));
    assign outOfRange = {2'b00, selAddr[31:2]} >= 32'(SIZE);
`ifdef MEM_RESP_MISALIGN_CHECK_EN
    assign misaligned = selAddr[1:0] != 2'b00;
`else
    logic [1:0] unusedAddrLsbs;
    assign unusedAddrLsbs = selAddr[1:0];
    assign misaligned     = 1'b0;
`endif
    assign accessErr = outOfRange || misaligned;
    assign memIdx    = selAddr[IdxW+1:2];

    // Request/response FSM, registered handshake outputs and the storage array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= StIdle;
            count      <= 4'd0;
            latWrite   <= 1'b0;
            latAddr    <= 32'd0;
            latWdata   <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid) begin
                        latWrite  <= req_write;
                        latAddr   <= req_addr;
                        latWdata  <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state      <= StResp;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= StWait;
                            count <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                StWait: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state      <= StResp;
                        resp_valid <= 1'b1;
                    end
                end
                StResp: begin
                    // Outputs hold until the initiator takes the response.
                    if (resp_ready) begin
                        state      <= StIdle;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= StIdle;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase

            if (commitNow) begin
                resp_err <= accessErr;
                if (accessErr) begin
                    resp_rdata <= 32'd0;
                end else if (selWrite) begin
                    mem[memIdx] <= selWdata;
                    resp_rdata  <= 32'd0;
                end else begin
                    resp_rdata <= mem[memIdx];
                end
            end
        end
    end

endmodule
